serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 164 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for serial_subtractor
//
// Purpose : common definitions imported by the bit-serial subtractor files.
// Contents: state_t  - controller states IDLE/RUN/DONE
//           DEFAULT_WIDTH - default operand width

package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor cell
//
// Purpose : computes x - y - bin for a single bit.
// Ports   : x    in  minuend bit
//           y    in  subtrahend bit
//           bin  in  borrow in
//           diff out difference bit
//           bo   out borrow out

module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bo
);

   assign diff = x ^ y ^ bin;
   // Borrow when y exceeds x outright, or when the bits tie and a borrow is pending.
   assign bo   = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, D = A - B over WIDTH clocks, LSB first
//
// Purpose : loads a/b in parallel on start, subtracts one bit per clock through a
//           single full_subtractor cell plus a borrow flop, then presents d/bout
//           in parallel with a one-cycle done strobe.
// Ports   : clk    in  rising-edge clock
//           rst_n  in  asynchronous active-low reset
//           start  in  request, sampled only in IDLE
//           a      in  [WIDTH-1:0] minuend, captured on accepted start
//           b      in  [WIDTH-1:0] subtrahend, captured on accepted start
//           busy   out high while bits are processed (RUN)
//           done   out one-cycle strobe, d/bout valid
//           d      out [WIDTH-1:0] (a - b) mod 2^WIDTH
//           bout   out final borrow, 1 iff a < b
//           ovf    out two's-complement overflow (only with SERIAL_SUB_OVF_EN)
// Macro   : SERIAL_SUB_OVF_EN adds the ovf port and its operand-MSB flops.

module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   ar_q, ar_d;
   logic [WIDTH-1:0]   br_q, br_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               fs_diff;
   logic               fs_bo;

`ifdef SERIAL_SUB_OVF_EN
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               ovf_q, ovf_d;
`endif

   full_subtractor u_fs (
      .x    (ar_q[0]),
      .y    (br_q[0]),
      .bin  (borrow_q),
      .diff (fs_diff),
      .bo   (fs_bo)
   );

   always_comb begin
      state_d  = state_q;
      ar_d     = ar_q;
      br_d     = br_q;
      res_d    = res_q;
      d_d      = d_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               ar_d     = a;
               br_d     = b;
               res_d    = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
`endif
               state_d  = RUN;
            end
         end

         RUN: begin
            ar_d     = ar_q >> 1;
            br_d     = br_q >> 1;
            // Result fills from the top, so after WIDTH shifts bit 0 sits at the LSB.
            res_d    = {fs_diff, res_q[WIDTH-1:1]};
            borrow_d = fs_bo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               d_d     = {fs_diff, res_q[WIDTH-1:1]};
               bout_d  = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
               // fs_diff here is the result MSB.
               ovf_d   = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
`endif
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ar_q     <= '0;
         br_q     <= '0;
         res_q    <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ar_q     <= ar_d;
         br_q     <= br_d;
         res_q    <= res_d;
         d_q      <= d_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign d    = d_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
//
// Purpose : directed vector table, randomized operations against an arithmetic
//           reference, continuous-start, mid-run reset and output-hold sequences.
// Macro   : SERIAL_SUB_OVF_EN also checks the ovf port.

module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .d     (d),
`ifdef SERIAL_SUB_OVF_EN
      .ovf   (ovf),
`endif
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_d;
      logic         exp_bout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y);
      int r;
      r = (int'(x) - int'(y) + 256) % 256;
      return r[W-1:0];
   endfunction

   function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y);
      return int'(x) < int'(y);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int sx, sy, r;
      sx = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
      sy = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
      r  = sx - sy;
      return (r > 127) || (r < -128);
   endfunction

   // Issues one operation from IDLE and checks latency, busy length, output hold and result.
   task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [W-1:0] exp_d, input logic exp_bout, input logic exp_ovf);
      logic [W-1:0] d_prev;
      logic         bout_prev;
      int           busy_cnt;
      int           hold_bad;
      bit           seen;
      @(negedge clk);
      d_prev    = d;
      bout_prev = bout;
      a = ai; b = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      busy_cnt = 0;
      hold_bad = 0;
      seen     = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (done) seen = 1;
         else begin
            if (busy) busy_cnt++;
            if (d !== d_prev || bout !== bout_prev) hold_bad++;
            @(negedge clk);
         end
      end
      check("done_seen", 32'(seen), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(W));
      check("hold_while_busy", 32'(hold_bad), 32'd0);
      check("busy_at_done", 32'(busy), 32'd0);
      check("d", 32'(d), 32'(exp_d));
      check("bout", 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", 32'(ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) $display("note: unknown ovf expectation");
`endif
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   logic [W-1:0] qa[40];
   logic [W-1:0] qb[40];
   logic [W-1:0] ra, rb, hold_d;
   logic         hold_b;
   int           bad;

   initial begin
      vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
      vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[5] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
      vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_d", 32'(d), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      foreach (vecs[i])
         do_op(vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_bout, vecs[i].exp_ovf);

      // Outputs hold through idle cycles.
      hold_d = d; hold_b = bout; bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (d !== hold_d || bout !== hold_b || done !== 1'b0) bad++;
      end
      check("hold_idle", 32'(bad), 32'd0);

      // Random operations against the arithmetic reference.
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i == 0) rb = ra;
         do_op(ra, rb, ref_d(ra, rb), ref_bout(ra, rb), ref_ovf(ra, rb));
      end

      // start held high with operands changing every cycle: accepts at cycles 0,10,20,30.
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i % 10 == 9) begin
            check("cont_done", 32'(done), 32'd1);
            check("cont_d", 32'(d), 32'(ref_d(qa[i-9], qb[i-9])));
            check("cont_bout", 32'(bout), 32'(ref_bout(qa[i-9], qb[i-9])));
         end else if (done !== 1'b0) bad++;
         qa[i] = W'($urandom);
         qb[i] = W'($urandom);
         a = qa[i]; b = qb[i]; start = 1'b1;
      end
      check("cont_no_extra_done", 32'(bad), 32'd0);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Reset after 4 bits of 0xAA - 0x55.
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_d", 32'(d), 32'd0);
      check("mid_rst_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("no_done_after_rst", 32'(bad), 32'd0);
      do_op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
